// File: rtl/csc_pkg.sv
// rtl/csc_pkg.sv - shared types, coefficients and clip helper for the YUV->RGB converter
//
// Purpose: FSM state encoding, Q16 conversion coefficients and the
//          32-bit signed -> 8-bit unsigned channel clip.
// Ports:   none (package).
package csc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_C0,
    S_C1,
    S_C2,
    S_C3,
    S_C4,
    S_W0,
    S_W1,
    S_W2
  } csc_state_t;

  localparam logic [17:0] COEF_Y  = 18'd76284;
  localparam logic [17:0] COEF_RV = 18'd104595;
  localparam logic [17:0] COEF_GU = 18'd25624;
  localparam logic [17:0] COEF_GV = 18'd53281;
  localparam logic [17:0] COEF_BU = 18'd132251;

  // Q16 accumulator to 8-bit channel: negative floors at 0, anything past
  // bit 23 saturates at 255, otherwise truncate the fraction.
  function automatic logic [7:0] clip_u8(input logic signed [31:0] v);
    if (v < 0)
      clip_u8 = 8'd0;
    else if (v[31:24] != 8'd0)
      clip_u8 = 8'd255;
    else
      clip_u8 = v[23:16];
  endfunction

endpackage

// File: rtl/csc_mac.sv
// rtl/csc_mac.sv - one signed multiplier with a rebasable add/subtract accumulator
//
// Purpose: multiplies a signed 10-bit offset by an unsigned coefficient and
//          adds/subtracts the product into a 32-bit accumulator.
// Ports:   clk, rst         - clock, async active-high reset
//          clr              - start a new sum from zero (also latches the product as the Y term)
//          rebase           - start the sum from the saved Y term instead of acc
//          sub              - subtract the product instead of adding
//          en               - write the sum into acc
//          opnd, coef       - multiplier operands
//          acc              - accumulator register
//          sum              - combinational base +/- product for this cycle
module csc_mac (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               rebase,
  input  logic               sub,
  input  logic               en,
  input  logic signed [9:0]  opnd,
  input  logic        [17:0] coef,
  output logic signed [31:0] acc,
  output logic signed [31:0] sum
);

  logic signed [31:0] opnd_x;
  logic signed [31:0] coef_x;
  logic signed [31:0] prod;
  logic signed [31:0] y_term;
  logic signed [31:0] base;

  assign opnd_x = {{22{opnd[9]}}, opnd};
  assign coef_x = {14'd0, coef};
  assign prod   = opnd_x * coef_x;

  // R, G and B all start from the Y term, so it is kept aside so the
  // accumulator can restart from it after finishing each channel.
  always_comb begin
    base = acc;
    if (clr)
      base = 32'sd0;
    else if (rebase)
      base = y_term;
    sum = sub ? (base - prod) : (base + prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= 32'sd0;
      y_term <= 32'sd0;
    end else begin
      if (en)
        acc <= sum;
      if (en && clr)
        y_term <= prod;
    end
  end

endmodule

// File: rtl/yuv_to_rgb_csc.sv
// rtl/yuv_to_rgb_csc.sv - even/odd pixel pair YUV to packed RGB converter
//
// Purpose: captures a pixel pair, computes RGB with two shared MACs over five
//          cycles, clips to 8 bits and emits three packed 16-bit words.
// Ports:   CLOCK_50_I, reset              - clock, async active-high reset
//          in_valid, in_ready             - input pair handshake
//          Y_pair, even_U/V, odd_U/V      - pixel pair samples
//          out_valid, out_ready           - output word handshake
//          out_data, out_last             - packed RGB word, third-word marker
module yuv_to_rgb_csc
  import csc_pkg::*;
(
  input  logic        CLOCK_50_I,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] Y_pair,
  input  logic [31:0] even_U,
  input  logic [31:0] even_V,
  input  logic [31:0] odd_U,
  input  logic [31:0] odd_V,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last
);

  csc_state_t state;

  logic [7:0] y_e, y_o, u_e, v_e, u_o, v_o;
  logic signed [9:0] yo_e, yo_o, uo_e, uo_o, vo_e, vo_o;
  logic signed [31:0] r_acc_e, r_acc_o;
  logic [7:0] b0, r1, g1, b1;

  logic clr, rebase, sub, en;
  logic signed [9:0] opnd_e, opnd_o;
  logic [17:0] coef;
  logic signed [31:0] acc_e, acc_o, sum_e, sum_o;

  // Interpolated chroma can over/undershoot; pin it to the 8-bit range.
  function automatic logic [7:0] clip_in(input logic [31:0] v);
    if (v[31])
      clip_in = 8'd0;
    else if (|v[30:8])
      clip_in = 8'd255;
    else
      clip_in = v[7:0];
  endfunction

  assign yo_e = $signed({2'b00, y_e}) - 10'sd16;
  assign yo_o = $signed({2'b00, y_o}) - 10'sd16;
  assign uo_e = $signed({2'b00, u_e}) - 10'sd128;
  assign uo_o = $signed({2'b00, u_o}) - 10'sd128;
  assign vo_e = $signed({2'b00, v_e}) - 10'sd128;
  assign vo_o = $signed({2'b00, v_o}) - 10'sd128;

  // Schedule: C0 loads Y, C1 makes R, C2/C3 make G from Y, C4 makes B from Y.
  always_comb begin
    clr    = 1'b0;
    rebase = 1'b0;
    sub    = 1'b0;
    en     = 1'b0;
    opnd_e = 10'sd0;
    opnd_o = 10'sd0;
    coef   = 18'd0;
    case (state)
      S_C0: begin opnd_e = yo_e; opnd_o = yo_o; coef = COEF_Y;  clr = 1'b1; en = 1'b1; end
      S_C1: begin opnd_e = vo_e; opnd_o = vo_o; coef = COEF_RV; en = 1'b1; end
      S_C2: begin opnd_e = uo_e; opnd_o = uo_o; coef = COEF_GU; rebase = 1'b1; sub = 1'b1; en = 1'b1; end
      S_C3: begin opnd_e = vo_e; opnd_o = vo_o; coef = COEF_GV; sub = 1'b1; en = 1'b1; end
      S_C4: begin opnd_e = uo_e; opnd_o = uo_o; coef = COEF_BU; rebase = 1'b1; end
      default: ;
    endcase
  end

  csc_mac u_mac_even (
    .clk(CLOCK_50_I), .rst(reset), .clr(clr), .rebase(rebase), .sub(sub), .en(en),
    .opnd(opnd_e), .coef(coef), .acc(acc_e), .sum(sum_e)
  );

  csc_mac u_mac_odd (
    .clk(CLOCK_50_I), .rst(reset), .clr(clr), .rebase(rebase), .sub(sub), .en(en),
    .opnd(opnd_o), .coef(coef), .acc(acc_o), .sum(sum_o)
  );

  always_ff @(posedge CLOCK_50_I or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 16'd0;
      out_last  <= 1'b0;
      y_e <= 8'd0; y_o <= 8'd0;
      u_e <= 8'd0; v_e <= 8'd0;
      u_o <= 8'd0; v_o <= 8'd0;
      r_acc_e <= 32'sd0;
      r_acc_o <= 32'sd0;
      b0 <= 8'd0; r1 <= 8'd0; g1 <= 8'd0; b1 <= 8'd0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          y_e      <= Y_pair[15:8];
          y_o      <= Y_pair[7:0];
          u_e      <= even_U[7:0];
          v_e      <= even_V[7:0];
          u_o      <= clip_in(odd_U);
          v_o      <= clip_in(odd_V);
          in_ready <= 1'b0;
          state    <= S_C0;
        end
        S_C0: state <= S_C1;
        S_C1: state <= S_C2;
        S_C2: begin
          // acc holds R here; it is overwritten by the G chain this cycle.
          r_acc_e <= acc_e;
          r_acc_o <= acc_o;
          state   <= S_C3;
        end
        S_C3: state <= S_C4;
        S_C4: begin
          // acc holds G, sum holds B, r_acc holds R.
          out_data  <= {clip_u8(r_acc_e), clip_u8(acc_e)};
          b0        <= clip_u8(sum_e);
          r1        <= clip_u8(r_acc_o);
          g1        <= clip_u8(acc_o);
          b1        <= clip_u8(sum_o);
          out_valid <= 1'b1;
          state     <= S_W0;
        end
        S_W0: if (out_ready) begin
          out_data <= {b0, r1};
          state    <= S_W1;
        end
        S_W1: if (out_ready) begin
          out_data <= {g1, b1};
          out_last <= 1'b1;
          state    <= S_W2;
        end
        S_W2: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_data  <= 16'd0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yuv_to_rgb_csc.sv
// tb/tb_yuv_to_rgb_csc.sv - directed self-checking bench for yuv_to_rgb_csc
module tb_yuv_to_rgb_csc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Y_pair;
  logic [31:0] even_U, even_V, odd_U, odd_V;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  yuv_to_rgb_csc dut (
    .CLOCK_50_I(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Y_pair(Y_pair),
    .even_U(even_U),
    .even_V(even_V),
    .odd_U(odd_U),
    .odd_V(odd_V),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic send(input string tag, input logic [15:0] y, input logic [31:0] eu,
                      input logic [31:0] ev, input logic [31:0] ou, input logic [31:0] ov);
    wait_ready(tag);
    Y_pair = y; even_U = eu; even_V = ev; odd_U = ou; odd_V = ov;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2);
    logic [15:0] exp_w [3];
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2;
    for (int k = 0; k < 3; k++) begin
      wait_valid($sformatf("%s_w%0d", tag, k));
      check($sformatf("%s_w%0d_data", tag, k), 32'(out_data), 32'(exp_w[k]));
      check($sformatf("%s_w%0d_last", tag, k), 32'(out_last), (k == 2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    int acc_idx [2];
    int n_acc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Y_pair = 16'd0; even_U = 32'd0; even_V = 32'd0; odd_U = 32'd0; odd_V = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    @(negedge clk) reset = 1'b0;

    send("black", 16'h1010, 32'd128, 32'd128, 32'd128, 32'd128);
    collect("black", 16'h0000, 16'h0000, 16'h0000);

    send("white", 16'hEBEB, 32'd128, 32'd128, 32'd128, 32'd128);
    collect("white", 16'hFEFE, 16'hFEFE, 16'hFEFE);

    send("y255", 16'hFFFF, 32'd128, 32'd128, 32'd128, 32'd128);
    collect("y255", 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // Even: Y=81 V=255 -> R sat, G floor, B=75. Odd: Y=128, U'=-5 clipped to 0.
    send("sat", 16'h5180, 32'd128, 32'd255, 32'hFFFF_FFFB, 32'd128);
    collect("sat", 16'hFF00, 16'h4B82, 16'hB400);

    // Odd U'=300 clipped to 255 -> B1 saturates, G1 floors.
    send("oddhi", 16'h1010, 32'd128, 32'd128, 32'd300, 32'd128);
    collect("oddhi", 16'h0000, 16'h0000, 16'h00FF);

    // Backpressure in S_W1 for four cycles.
    send("bp", 16'h5180, 32'd128, 32'd255, 32'hFFFF_FFFB, 32'd128);
    wait_valid("bp_w0");
    check("bp_w0_data", 32'(out_data), 32'hFF00);
    @(negedge clk);
    check("bp_w1_data", 32'(out_data), 32'h4B82);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_data", i), 32'(out_data), 32'h4B82);
      check($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_w2_data", 32'(out_data), 32'hB400);
    check("bp_w2_last", 32'(out_last), 32'd1);
    @(negedge clk);
    check("bp_done_in_ready", 32'(in_ready), 32'd1);
    check("bp_done_valid", 32'(out_valid), 32'd0);

    // Back-to-back pairs: accept spacing with a free-flowing output.
    Y_pair = 16'h1010; even_U = 32'd128; even_V = 32'd128; odd_U = 32'd128; odd_V = 32'd128;
    in_valid = 1'b1;
    n_acc = 0;
    acc_idx[0] = 0; acc_idx[1] = 0;
    for (int i = 0; i < 40 && n_acc < 2; i++) begin
      if (i > 0) @(negedge clk);
      if (in_ready && in_valid) begin
        acc_idx[n_acc] = i;
        n_acc++;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd2);
    check("b2b_spacing", 32'(acc_idx[1] - acc_idx[0]), 32'd9);
    wait_ready("b2b_drain");

    // Reset in S_C2 discards the pair; the next pair is clean.
    send("abort", 16'hFFFF, 32'd128, 32'd128, 32'd128, 32'd128);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    @(negedge clk) reset = 1'b0;
    send("post", 16'h5180, 32'd128, 32'd255, 32'hFFFF_FFFB, 32'd128);
    collect("post", 16'hFF00, 16'h4B82, 16'hB400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
